// File: rtl/cva6_hpdcache_cmo_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cva6_hpdcache_cmo_arbiter: locked round-robin CMO arbiter with per-source
// outstanding counters and completion routing.  Revision: 1.0
// ----------------------------------------------------------------------------
module cva6_hpdcache_cmo_arbiter #(
  parameter int unsigned NREQ    = 3,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned OP_W    = 4,
  parameter int unsigned TID_W   = 6,
  parameter int unsigned MAX_OUT = 4,
  parameter int unsigned SID_W   = $clog2(NREQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*ADDR_W-1:0]  req_addr_i,
  input  logic [NREQ*OP_W-1:0]    req_op_i,
  input  logic [NREQ*TID_W-1:0]   req_tid_i,
  output logic                    dcache_req_valid_o,
  input  logic                    dcache_req_ready_i,
  output logic [ADDR_W-1:0]       dcache_req_addr_o,
  output logic [OP_W-1:0]         dcache_req_op_o,
  output logic [TID_W-1:0]        dcache_req_tid_o,
  output logic [SID_W-1:0]        dcache_req_sid_o,
  input  logic                    dcache_ack_valid_i,
  input  logic [SID_W-1:0]        dcache_ack_sid_i,
  input  logic [TID_W-1:0]        dcache_ack_tid_i,
  output logic [NREQ-1:0]         ack_valid_o,
  output logic [TID_W-1:0]        ack_tid_o,
  output logic [NREQ-1:0]         busy_o,
  output logic                    idle_o,
  output logic                    err_o
);

  typedef enum logic [0:0] {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e           state_q;
  logic [SID_W-1:0] ptr_q;
  logic [SID_W-1:0] gnt_q;
  logic [3:0]       cnt_q [NREQ];
  logic             err_q;

  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  inc;
  logic             sel_valid;
  logic [SID_W-1:0] sel_idx;
  logic [SID_W-1:0] scan_idx;
  logic [SID_W-1:0] cur_idx;
  logic             cur_valid;
  logic             hs;
  logic [SID_W-1:0] ptr_nxt;
  logic             ack_in_range;
  logic             ack_cnt_nz;
  logic             ack_ok;
  logic             ack_err;

  generate
    for (genvar k = 0; k < NREQ; k++) begin : g_req
      assign elig[k]        = req_valid_i[k] && (cnt_q[k] < 4'(MAX_OUT));
      assign inc[k]         = hs && (cur_idx == SID_W'(k));
      assign req_ready_o[k] = dcache_req_ready_i && cur_valid && (cur_idx == SID_W'(k));
      assign ack_valid_o[k] = ack_ok && (dcache_ack_sid_i == SID_W'(k));
      assign busy_o[k]      = (cnt_q[k] != 4'd0);
    end
  endgenerate

  // Scan from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    scan_idx  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      scan_idx = SID_W'((32'(ptr_q) + 32'(i)) % NREQ);
      if (elig[scan_idx]) begin
        sel_valid = 1'b1;
        sel_idx   = scan_idx;
      end
    end
  end

  assign cur_idx   = (state_q == ST_LOCK) ? gnt_q : sel_idx;
  assign cur_valid = (state_q == ST_LOCK) ? req_valid_i[gnt_q] : sel_valid;
  assign hs        = cur_valid && dcache_req_ready_i;
  assign ptr_nxt   = (cur_idx == SID_W'(NREQ - 1)) ? '0 : cur_idx + SID_W'(1);

  always_comb begin
    dcache_req_addr_o = req_addr_i[ADDR_W-1:0];
    dcache_req_op_o   = req_op_i[OP_W-1:0];
    dcache_req_tid_o  = req_tid_i[TID_W-1:0];
    for (int k = 0; k < NREQ; k++) begin
      if (cur_idx == SID_W'(k)) begin
        dcache_req_addr_o = req_addr_i[k*ADDR_W +: ADDR_W];
        dcache_req_op_o   = req_op_i[k*OP_W +: OP_W];
        dcache_req_tid_o  = req_tid_i[k*TID_W +: TID_W];
      end
    end
  end

  assign dcache_req_valid_o = cur_valid;
  assign dcache_req_sid_o   = cur_idx;

  always_comb begin
    ack_in_range = 1'b0;
    ack_cnt_nz   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (dcache_ack_sid_i == SID_W'(k)) begin
        ack_in_range = 1'b1;
        ack_cnt_nz   = (cnt_q[k] != 4'd0);
      end
    end
  end

  // A handshake landing in the same cycle makes an ack at count zero legal.
  assign ack_ok  = dcache_ack_valid_i && ack_in_range &&
                   (ack_cnt_nz || (hs && (cur_idx == dcache_ack_sid_i)));
  assign ack_err = dcache_ack_valid_i && !ack_ok;

  assign ack_tid_o = dcache_ack_tid_i;
  assign idle_o    = (state_q == ST_ARB) && (busy_o == '0);
  assign err_o     = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_ARB;
      ptr_q   <= '0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        cnt_q[k] <= 4'd0;
      end
    end else begin
      if (ack_err) begin
        err_q <= 1'b1;
      end
      for (int k = 0; k < NREQ; k++) begin
        cnt_q[k] <= cnt_q[k] + 4'(inc[k]) - 4'(ack_valid_o[k]);
      end
      if (hs) begin
        ptr_q <= ptr_nxt;
      end
      case (state_q)
        ST_ARB: begin
          if (sel_valid && !dcache_req_ready_i) begin
            state_q <= ST_LOCK;
            gnt_q   <= sel_idx;
          end
        end
        ST_LOCK: begin
          if (hs) begin
            state_q <= ST_ARB;
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cva6_hpdcache_cmo_arbiter.sv
`default_nettype none
// Bench for cva6_hpdcache_cmo_arbiter: directed traffic with a per-cycle reference model.
module tb_cva6_hpdcache_cmo_arbiter;

  localparam int NREQ    = 3;
  localparam int ADDR_W  = 64;
  localparam int OP_W    = 4;
  localparam int TID_W   = 6;
  localparam int MAX_OUT = 4;
  localparam int SID_W   = 2;

  logic                   clk_i;
  logic                   rst_ni;
  logic [NREQ-1:0]        req_valid_i;
  logic [NREQ-1:0]        req_ready_o;
  logic [NREQ*ADDR_W-1:0] req_addr_i;
  logic [NREQ*OP_W-1:0]   req_op_i;
  logic [NREQ*TID_W-1:0]  req_tid_i;
  logic                   dcache_req_valid_o;
  logic                   dcache_req_ready_i;
  logic [ADDR_W-1:0]      dcache_req_addr_o;
  logic [OP_W-1:0]        dcache_req_op_o;
  logic [TID_W-1:0]       dcache_req_tid_o;
  logic [SID_W-1:0]       dcache_req_sid_o;
  logic                   dcache_ack_valid_i;
  logic [SID_W-1:0]       dcache_ack_sid_i;
  logic [TID_W-1:0]       dcache_ack_tid_i;
  logic [NREQ-1:0]        ack_valid_o;
  logic [TID_W-1:0]       ack_tid_o;
  logic [NREQ-1:0]        busy_o;
  logic                   idle_o;
  logic                   err_o;

  cva6_hpdcache_cmo_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .OP_W(OP_W), .TID_W(TID_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_op_i(req_op_i), .req_tid_i(req_tid_i),
    .dcache_req_valid_o(dcache_req_valid_o), .dcache_req_ready_i(dcache_req_ready_i),
    .dcache_req_addr_o(dcache_req_addr_o), .dcache_req_op_o(dcache_req_op_o),
    .dcache_req_tid_o(dcache_req_tid_o), .dcache_req_sid_o(dcache_req_sid_o),
    .dcache_ack_valid_i(dcache_ack_valid_i), .dcache_ack_sid_i(dcache_ack_sid_i),
    .dcache_ack_tid_i(dcache_ack_tid_i),
    .ack_valid_o(ack_valid_o), .ack_tid_o(ack_tid_o),
    .busy_o(busy_o), .idle_o(idle_o), .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Reference model: outstanding count per source, rotating priority, lock holder.
  int m_cnt [NREQ];
  int m_ptr, m_gnt;
  bit m_lock, m_err;
  int gid, s;
  bit gv, hs_m, legal;
  logic [NREQ-1:0] exp_busy, exp_ackv, exp_rdy;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      foreach (m_cnt[k]) m_cnt[k] = 0;
      m_ptr = 0; m_gnt = 0; m_lock = 0; m_err = 0;
    end
    gv = 0; gid = 0;
    if (m_lock) begin
      gid = m_gnt;
      gv  = req_valid_i[gid];
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        int k;
        k = (m_ptr + i) % NREQ;
        if (!gv && req_valid_i[k] && m_cnt[k] < MAX_OUT) begin
          gv = 1; gid = k;
        end
      end
    end
    hs_m = gv && dcache_req_ready_i;
    s = int'(dcache_ack_sid_i);
    legal = 0;
    if (dcache_ack_valid_i && s < NREQ)
      legal = (m_cnt[s] > 0) || (hs_m && gid == s);
    exp_ackv = legal ? NREQ'(1 << s) : '0;
    exp_rdy  = hs_m ? NREQ'(1 << gid) : '0;
    for (int k = 0; k < NREQ; k++) exp_busy[k] = (m_cnt[k] != 0);

    chk("m_req_valid", dcache_req_valid_o, gv);
    if (gv) begin
      chk("m_req_sid", dcache_req_sid_o, gid);
      chk("m_req_addr", dcache_req_addr_o, req_addr_i[gid*ADDR_W +: ADDR_W]);
      chk("m_req_op", dcache_req_op_o, req_op_i[gid*OP_W +: OP_W]);
      chk("m_req_tid", dcache_req_tid_o, req_tid_i[gid*TID_W +: TID_W]);
    end
    chk("m_req_ready", req_ready_o, exp_rdy);
    chk("m_ack_valid", ack_valid_o, exp_ackv);
    chk("m_ack_tid", ack_tid_o, dcache_ack_tid_i);
    chk("m_busy", busy_o, exp_busy);
    chk("m_idle", idle_o, !m_lock && exp_busy == '0);
    chk("m_err", err_o, m_err);

    if (rst_ni) begin
      if (hs_m) begin
        m_cnt[gid]++;
        m_ptr  = (gid + 1) % NREQ;
        m_lock = 0;
      end else if (gv && !m_lock) begin
        m_lock = 1;
        m_gnt  = gid;
      end
      if (legal) m_cnt[s]--;
      if (dcache_ack_valid_i && !legal) m_err = 1;
    end
  end

  task automatic ack(input int sid, input logic [TID_W-1:0] tid);
    dcache_ack_valid_i = 1'b1;
    dcache_ack_sid_i   = SID_W'(sid);
    dcache_ack_tid_i   = tid;
    cyc();
    dcache_ack_valid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    req_valid_i = '0; dcache_req_ready_i = 1'b0;
    dcache_ack_valid_i = 1'b0; dcache_ack_sid_i = '0; dcache_ack_tid_i = '0;
    for (int k = 0; k < NREQ; k++) begin
      req_addr_i[k*ADDR_W +: ADDR_W] = 64'h8000_0000_0000_1000 + 64'(k) * 64'h40;
      req_op_i[k*OP_W +: OP_W]       = OP_W'(k + 3);
      req_tid_i[k*TID_W +: TID_W]    = TID_W'(k + 10);
    end
    repeat (2) @(posedge clk_i);
    #2;
    chk("rst_req_valid", dcache_req_valid_o, 0);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_idle", idle_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_err", err_o, 0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    cyc();

    // Round-robin over all three requesters
    req_valid_i = 3'b111; dcache_req_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 chk("rr_sid", dcache_req_sid_o, c % 3);
      cyc();
    end
    req_valid_i = '0;
    #1 chk("rr_busy", busy_o, 3'b111);
    for (int c = 0; c < 6; c++) begin
      dcache_ack_valid_i = 1'b1; dcache_ack_sid_i = SID_W'(c % 3); dcache_ack_tid_i = TID_W'(c);
      #1 chk("rr_drain_ack", ack_valid_o, 64'(1 << (c % 3)));
      cyc();
    end
    dcache_ack_valid_i = 1'b0;
    #1 chk("rr_drained_idle", idle_o, 1);

    // Lock on requester 1 while the cache stalls
    dcache_req_ready_i = 1'b0; req_valid_i = 3'b010;
    #1 chk("lock_sid_c1", dcache_req_sid_o, 1);
    cyc();
    req_valid_i = 3'b011;
    for (int c = 0; c < 2; c++) begin
      #1 chk("lock_sid_hold", dcache_req_sid_o, 1);
      chk("lock_rdy0_low", req_ready_o, 3'b000);
      cyc();
    end
    dcache_req_ready_i = 1'b1;
    #1 chk("lock_release_rdy", req_ready_o, 3'b010);
    cyc();
    req_valid_i = 3'b101;
    #1 chk("lock_next_sid2", dcache_req_sid_o, 2);
    cyc();
    req_valid_i = 3'b001;
    #1 chk("lock_then_sid0", dcache_req_sid_o, 0);
    cyc();
    req_valid_i = '0;
    ack(0, 6'h01); ack(1, 6'h02); ack(2, 6'h03);

    // Outstanding limit on requester 0
    req_valid_i = 3'b001;
    repeat (4) begin
      #1 chk("lim_fill_sid", dcache_req_sid_o, 0);
      cyc();
    end
    req_valid_i = 3'b011;
    #1 chk("lim_skip_sid", dcache_req_sid_o, 1);
    chk("lim_skip_rdy", req_ready_o, 3'b010);
    cyc();
    req_valid_i = 3'b001;
    dcache_ack_valid_i = 1'b1; dcache_ack_sid_i = 2'd0; dcache_ack_tid_i = 6'h15;
    #1 chk("lim_ack_valid", ack_valid_o, 3'b001);
    chk("lim_ack_tid", ack_tid_o, 6'h15);
    chk("lim_still_full", dcache_req_valid_o, 0);
    cyc();
    dcache_ack_valid_i = 1'b0;
    #1 chk("lim_eligible", dcache_req_valid_o, 1);
    chk("lim_eligible_sid", dcache_req_sid_o, 0);
    cyc();
    req_valid_i = '0;
    repeat (4) ack(0, 6'h20);
    ack(1, 6'h21);

    // Simultaneous handshake and ack on requester 2
    req_valid_i = 3'b100;
    cyc();
    dcache_ack_valid_i = 1'b1; dcache_ack_sid_i = 2'd2; dcache_ack_tid_i = 6'h2a;
    #1 chk("sim_ack_pulse", ack_valid_o, 3'b100);
    cyc();
    req_valid_i = '0; dcache_ack_valid_i = 1'b0;
    #1 chk("sim_busy2", busy_o, 3'b100);
    dcache_ack_valid_i = 1'b1;
    #1 chk("sim_drain", ack_valid_o, 3'b100);
    cyc();
    req_valid_i = 3'b100;
    #1 chk("sim_zero_cnt_ack", ack_valid_o, 3'b100);
    cyc();
    req_valid_i = '0; dcache_ack_valid_i = 1'b0;
    #1 chk("sim_no_err", err_o, 0);
    chk("sim_busy_clear", busy_o, 3'b000);

    // Spurious acks
    dcache_ack_valid_i = 1'b1; dcache_ack_sid_i = 2'd1; dcache_ack_tid_i = 6'h07;
    #1 chk("err_ack_dropped", ack_valid_o, 0);
    chk("err_not_yet", err_o, 0);
    cyc();
    dcache_ack_valid_i = 1'b0;
    #1 chk("err_set", err_o, 1);
    dcache_ack_valid_i = 1'b1; dcache_ack_sid_i = 2'd3;
    #1 chk("err_oor_dropped", ack_valid_o, 0);
    cyc();
    dcache_ack_valid_i = 1'b0; req_valid_i = 3'b001;
    cyc();
    req_valid_i = '0;
    #1 chk("err_sticky", err_o, 1);
    ack(0, 6'h30);

    // Reset while locked on requester 2 with three outstanding
    req_valid_i = 3'b100;
    repeat (3) cyc();
    dcache_req_ready_i = 1'b0;
    cyc();
    #1 chk("rl_busy", busy_o, 3'b100);
    chk("rl_not_idle", idle_o, 0);
    rst_ni = 1'b0; req_valid_i = '0;
    #1 chk("rl_busy_cleared", busy_o, 0);
    chk("rl_idle", idle_o, 1);
    chk("rl_err_cleared", err_o, 0);
    chk("rl_req_valid", dcache_req_valid_o, 0);
    repeat (2) cyc();
    rst_ni = 1'b1;
    cyc();
    #1 chk("rl_idle_after", idle_o, 1);
    dcache_ack_valid_i = 1'b1; dcache_ack_sid_i = 2'd2; dcache_ack_tid_i = 6'h33;
    #1 chk("rl_lost_ack", ack_valid_o, 0);
    cyc();
    dcache_ack_valid_i = 1'b0;
    #1 chk("rl_lost_err", err_o, 1);
    repeat (2) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
